// File: rtl/harz_pkg.sv
// Shared types for the MSX slot bus arbiter: host request codes, owner FSM states,
// the slot bus bundle and helpers that derive slot strobes from a host request.
package harz_pkg;

  typedef enum logic [2:0] {
    NONE   = 3'd0,
    MEM_RD = 3'd1,
    MEM_WR = 3'd2,
    IO_RD  = 3'd3,
    IO_WR  = 3'd4
  } harz_req_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CPU,
    ST_H_SETUP,
    ST_H_STROBE,
    ST_H_RELEASE
  } arb_state_t;

  typedef struct packed {
    logic        merq;
    logic        iorq;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } slot_bus_t;

  function automatic logic req_valid(harz_req_t kind);
    return kind inside {MEM_RD, MEM_WR, IO_RD, IO_WR};
  endfunction

  function automatic logic req_is_io(harz_req_t kind);
    return (kind == IO_RD) || (kind == IO_WR);
  endfunction

  function automatic logic req_is_wr(harz_req_t kind);
    return (kind == MEM_WR) || (kind == IO_WR);
  endfunction

  function automatic slot_bus_t host_bus(harz_req_t kind, logic [15:0] addr,
                                         logic [7:0] wdata, logic strobe);
    slot_bus_t b;
    b.merq  = ~req_is_io(kind);
    b.iorq  = req_is_io(kind);
    b.rd    = strobe & ~req_is_wr(kind);
    b.wr    = strobe & req_is_wr(kind);
    b.addr  = addr;
    b.wdata = wdata;
    return b;
  endfunction

endpackage

// File: rtl/slot_bus_arbiter_host_req_latch.sv
// Host-side front end: edge-based request acceptance, capture of address/data/kind,
// and the busy flag seen by the host.
module host_req_latch
  import harz_pkg::*;
(
  input  logic        i_CLK,
  input  logic        i_RST,
  input  harz_req_t   i_h_req,
  input  logic [15:0] i_h_addr,
  input  logic [7:0]  i_h_wdata,
  input  logic        i_accept,
  input  logic        i_done,
  output logic        o_new_req,
  output harz_req_t   o_kind,
  output logic [15:0] o_addr,
  output logic [7:0]  o_wdata,
  output logic        o_busy
);

  logic        seen_q, seen_d;
  logic        busy_q, busy_d;
  harz_req_t   kind_q, kind_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;

  // A held request level is served once; the host must return to NONE to re-arm.
  assign o_new_req = req_valid(i_h_req) && !seen_q && !busy_q;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    seen_d  = seen_q;
    busy_d  = busy_q;
    kind_d  = kind_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (i_h_req == NONE) seen_d = 1'b0;
    else if (i_accept)   seen_d = 1'b1;
    if (i_accept) begin
      busy_d  = 1'b1;
      kind_d  = i_h_req;
      addr_d  = i_h_addr;
      wdata_d = i_h_wdata;
    end else if (i_done) begin
      busy_d = 1'b0;
    end
  end

  // NOTE: state updates use <= so every flop samples pre-edge values regardless of order.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      seen_q  <= 1'b0;
      busy_q  <= 1'b0;
      kind_q  <= NONE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      seen_q  <= seen_d;
      busy_q  <= busy_d;
      kind_q  <= kind_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign o_kind  = kind_q;
  assign o_addr  = addr_q;
  assign o_wdata = wdata_q;
  assign o_busy  = busy_q;

endmodule

// File: rtl/slot_bus_arbiter.sv
// Registered owner FSM sharing the MSX slot bus between the Z80 and the Harz host
// port; a starvation counter guarantees the host a slot under back-to-back CPU cycles.
module slot_bus_arbiter
  import harz_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned SETUP_CYC    = 1
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic        i_z_mreq,
  input  logic        i_z_iorq,
  input  logic        i_z_rd,
  input  logic        i_z_wr,
  input  logic [15:0] i_z_addr,
  input  logic [7:0]  i_z_wdata,
  output logic        o_z_wait_n,
  output logic [7:0]  o_z_rdata,
  input  harz_req_t   i_h_req,
  input  logic [15:0] i_h_addr,
  input  logic [7:0]  i_h_wdata,
  output logic        o_h_busy,
  output logic [7:0]  o_h_rdata,
  output logic        o_s_merq,
  output logic        o_s_iorq,
  output logic        o_s_rd,
  output logic        o_s_wr,
  output logic [15:0] o_s_addr,
  output logic [7:0]  o_s_wdata,
  input  logic        i_s_busy,
  input  logic [7:0]  i_s_rdata,
  output logic        o_owner
);

  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);
  // A SETUP_CYC of 0 still spends the single unavoidable cycle in ST_H_SETUP.
  localparam logic [1:0] SETUP_LAST = (SETUP_CYC == 0) ? 2'd0 : 2'(SETUP_CYC - 1);

  arb_state_t  state_q, state_d;
  slot_bus_t   s_q, s_d, cpu_bus;
  logic [7:0]  starve_q, starve_d;
  logic [1:0]  setup_cnt_q, setup_cnt_d;
  logic        strobe_first_q, strobe_first_d;
  logic        z_wait_n_q, z_wait_n_d;
  logic [7:0]  z_rdata_q, z_rdata_d;
  logic [7:0]  h_rdata_q, h_rdata_d;
  logic        owner_q, owner_d;

  logic        h_accept, h_done, h_new;
  harz_req_t   h_kind;
  logic [15:0] h_addr;
  logic [7:0]  h_wdata;
  logic        cpu_active, starve_full, cpu_blocked;

  host_req_latch u_host_req_latch (
    .i_CLK     (i_CLK),
    .i_RST     (i_RST),
    .i_h_req   (i_h_req),
    .i_h_addr  (i_h_addr),
    .i_h_wdata (i_h_wdata),
    .i_accept  (h_accept),
    .i_done    (h_done),
    .o_new_req (h_new),
    .o_kind    (h_kind),
    .o_addr    (h_addr),
    .o_wdata   (h_wdata),
    .o_busy    (o_h_busy)
  );

  assign cpu_active  = i_z_mreq | i_z_iorq;
  assign starve_full = (starve_q == STARVE_MAX);
  assign cpu_blocked = starve_full && h_new;
  assign cpu_bus     = '{merq: i_z_mreq, iorq: i_z_iorq, rd: i_z_rd, wr: i_z_wr,
                         addr: i_z_addr, wdata: i_z_wdata};

  always_comb begin
    state_d        = state_q;
    s_d            = '0;
    starve_d       = starve_q;
    setup_cnt_d    = setup_cnt_q;
    strobe_first_d = strobe_first_q;
    z_rdata_d      = z_rdata_q;
    h_rdata_d      = h_rdata_q;
    h_accept       = 1'b0;
    h_done         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_active && !cpu_blocked) begin
          state_d = ST_CPU;
          s_d     = cpu_bus;
        end else if (h_new) begin
          h_accept    = 1'b1;
          state_d     = ST_H_SETUP;
          setup_cnt_d = '0;
          s_d         = host_bus(i_h_req, i_h_addr, i_h_wdata, 1'b0);
        end
      end
      ST_CPU: begin
        z_rdata_d = i_s_rdata;
        if (cpu_active) begin
          s_d = cpu_bus;
        end else begin
          state_d = ST_IDLE;
          if (h_new && !starve_full) starve_d = starve_q + 8'd1;
        end
      end
      ST_H_SETUP: begin
        s_d = host_bus(h_kind, h_addr, h_wdata, setup_cnt_q == SETUP_LAST);
        if (setup_cnt_q == SETUP_LAST) begin
          state_d        = ST_H_STROBE;
          strobe_first_d = 1'b1;
        end else begin
          setup_cnt_d = setup_cnt_q + 2'd1;
        end
      end
      ST_H_STROBE: begin
        // The slot may not have raised busy yet in the first strobe cycle.
        if (strobe_first_q || i_s_busy) begin
          s_d            = host_bus(h_kind, h_addr, h_wdata, 1'b1);
          strobe_first_d = 1'b0;
        end else begin
          s_d     = host_bus(h_kind, h_addr, h_wdata, 1'b0);
          state_d = ST_H_RELEASE;
          if (!req_is_wr(h_kind)) h_rdata_d = i_s_rdata;
        end
      end
      ST_H_RELEASE: begin
        h_done   = 1'b1;
        starve_d = '0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    z_wait_n_d = !(cpu_active && (state_d != ST_CPU));
    owner_d    = state_d inside {ST_H_SETUP, ST_H_STROBE, ST_H_RELEASE};
  end

  // NOTE: only control and output registers here carry reset; there is no storage array.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q        <= ST_IDLE;
      s_q            <= '0;
      starve_q       <= '0;
      setup_cnt_q    <= '0;
      strobe_first_q <= 1'b0;
      z_wait_n_q     <= 1'b1;
      z_rdata_q      <= '0;
      h_rdata_q      <= '0;
      owner_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      s_q            <= s_d;
      starve_q       <= starve_d;
      setup_cnt_q    <= setup_cnt_d;
      strobe_first_q <= strobe_first_d;
      z_wait_n_q     <= z_wait_n_d;
      z_rdata_q      <= z_rdata_d;
      h_rdata_q      <= h_rdata_d;
      owner_q        <= owner_d;
    end
  end

  assign o_s_merq   = s_q.merq;
  assign o_s_iorq   = s_q.iorq;
  assign o_s_rd     = s_q.rd;
  assign o_s_wr     = s_q.wr;
  assign o_s_addr   = s_q.addr;
  assign o_s_wdata  = s_q.wdata;
  assign o_z_wait_n = (state_q == ST_CPU) ? ~i_s_busy : z_wait_n_q;
  assign o_z_rdata  = (state_q == ST_CPU) ? i_s_rdata : z_rdata_q;
  assign o_h_rdata  = h_rdata_q;
  assign o_owner    = owner_q;

endmodule

// File: doc/slot_bus_arbiter.md
# slot_bus_arbiter

Arbitrates the MSX slot bus between the Z80 CPU and the Harz host-access port. Strobes are granted only at cycle boundaries, and a starvation counter guarantees the host a slot. The block sits between the CPU/Harz front ends and the basic slot unit. It replaces the ad-hoc CPU/host mux with a registered, cycle-safe owner FSM.

## Interface
- `STARVE_LIMIT`, 8: consecutive CPU cycles allowed while a host request is pending (1..255).
- `SETUP_CYC`, 1: `i_CLK` cycles between driving address/data and asserting `rd`/`wr` on a host access (0..3).
- `i_CLK`  in  1  system clock; the only clock.
- `i_RST`  in  1  asynchronous, active-high reset.
- `i_z_mreq`, `i_z_iorq`, `i_z_rd`, `i_z_wr`  in  1 each  CPU strobes, active-high, already inverted.
- `i_z_addr`  in  16  CPU address.
- `i_z_wdata`  in  8  CPU write data.
- `o_z_wait_n`  out  1  low = stall CPU.
- `o_z_rdata`  out  8  read data to the CPU.
- `i_h_req`  in  3  host request code: NONE, MEM_RD, MEM_WR, IO_RD, IO_WR (shared package enum).
- `i_h_addr`  in  16  host address.
- `i_h_wdata`  in  8  host write data.
- `o_h_busy`  out  1  high from request acceptance until `o_h_rdata` is valid.
- `o_h_rdata`  out  8  host read data.
- `o_s_merq`, `o_s_iorq`, `o_s_rd`, `o_s_wr`  out  1 each  slot bus strobes, active-high.
- `o_s_addr`  out  16  slot bus address.
- `o_s_wdata`  out  8  slot bus write data.
- `i_s_busy`  in  1  slot bus wait request.
- `i_s_rdata`  in  8  slot bus read data.
- `o_owner`  out  1  0 = CPU owns the bus, 1 = host owns the bus (debug/LED).

## Operation
- FSM states: `ST_IDLE`, `ST_CPU`, `ST_H_SETUP`, `ST_H_STROBE`, `ST_H_RELEASE`.
- **ST_IDLE** (no strobes driven, owner=CPU):
  - If CPU `mreq|iorq` is high and the CPU is not blocked, go to `ST_CPU`.
  - Otherwise, if `i_h_req`≠NONE, latch addr/wdata/kind, set `o_h_busy`, and go to `ST_H_SETUP`.
  - If both are present in the same cycle, the CPU wins unless the starve counter equals `STARVE_LIMIT`.
- **ST_CPU**:
  - Slot outputs follow the registered CPU inputs.
  - `o_z_wait_n = ~i_s_busy`.
  - `o_z_rdata = i_s_rdata`.
  - On CPU `mreq|iorq` falling: increment the starve counter if a host request is pending (saturating), then go to `ST_IDLE`.
- **Blocked CPU**: the starve counter is at the limit, or a host access is in progress.
  - A new CPU cycle is not forwarded to the slot bus.
  - `o_z_wait_n` is driven low until the FSM returns to `ST_IDLE` and grants the CPU.
- **ST_H_SETUP**:
  - Drive `merq`/`iorq`, `addr`, `wdata`; hold `rd`/`wr` low.
  - Stay `SETUP_CYC` cycles, then go to `ST_H_STROBE`. With `SETUP_CYC`=0, pass through in one cycle.
- **ST_H_STROBE**:
  - Assert `rd` or `wr`.
  - `i_s_busy` is ignored in the first strobe cycle; it is sampled from the second cycle onward.
  - When `i_s_busy` is low: capture `i_s_rdata` into `o_h_rdata` (reads only), deassert `rd`/`wr`, go to `ST_H_RELEASE`.
- **ST_H_RELEASE**:
  - Deassert `merq`/`iorq` and clear `o_h_busy`.
  - Clear the starve counter; go to `ST_IDLE`.
- **Host handshake**:
  - A request is accepted only while `o_h_busy`=0 and the FSM is in `ST_IDLE`.
  - The host must drop `i_h_req` to NONE for at least one cycle after `o_h_busy` falls. A level held high is not re-accepted.
  - Acceptance is edge-based: track the previous request with a `h_req_seen` flag, cleared when `i_h_req`=NONE.
- Host write data is never routed to `o_z_rdata`. CPU data is never routed to `o_h_rdata`.

## Timing
- Reset values:
  - All `o_s_*` strobes 0; `o_s_addr` and `o_s_wdata` 0.
  - `o_z_wait_n`=1, `o_z_rdata`=0.
  - `o_h_busy`=0, `o_h_rdata`=0.
  - `o_owner`=0, state `ST_IDLE`, starve counter 0, `h_req_seen`=0.
- All outputs are registered except `o_z_wait_n` and `o_z_rdata` in `ST_CPU`, which are combinational from `i_s_busy`/`i_s_rdata`.
- CPU path latency: CPU strobe to slot strobe is 1 cycle (input register).
- Host access with `i_s_busy` never high:
  - `o_h_busy` rises 1 cycle after `i_h_req` is seen.
  - `rd`/`wr` assert `SETUP_CYC`+1 cycles later.
  - The strobe is held for 2 cycles.
  - `o_h_busy` falls in `ST_H_RELEASE`.
- Reset mid-access: all strobes drop immediately (asynchronous), the access is lost, and `o_h_busy` is 0.

## Structure
- Shared package `harz_pkg`: `harz_req_t` enum (NONE, MEM_RD, MEM_WR, IO_RD, IO_WR) and `arb_state_t`.
- Natural sub-module: `host_req_latch`. It handles request edge detection, address/data/kind capture and the `o_h_busy` flag.
- The FSM and the starve counter live in the top level.

## Test plan
- **CPU memory read, no host:** `mreq`+`rd` at `0x4000`, `i_s_rdata`=`0xA5` → `o_s_merq` and `o_s_rd` high 1 cycle later; `o_z_rdata`=`0xA5`; `o_z_wait_n`=1 throughout.
- **Host IO write from idle:** IO_WR, addr `0x00A0`, data `0x3C`, `SETUP_CYC`=1 → `o_s_iorq` for 4 cycles; `o_s_wr` high for 2 cycles; `o_s_wdata`=`0x3C`; `o_h_busy` high for 4 cycles.
- **Collision:** CPU `mreq` arrives 1 cycle after host acceptance → `o_z_wait_n`=0 and the CPU cycle is not forwarded; the CPU is granted the cycle after `ST_H_RELEASE`; the host access completes unmodified.
- **Starvation:** `STARVE_LIMIT`=2 with back-to-back CPU cycles and a host MEM_RD pending → exactly 2 CPU cycles pass; the third is held with `o_z_wait_n`=0 until the host read returns `o_h_rdata`.
- **Slot wait:** host MEM_RD with `i_s_busy` high for 5 cycles → `o_s_rd` held 6 cycles; `o_h_rdata` is captured only after `i_s_busy` falls.
- **Reset mid-strobe:** `i_RST` pulse during `ST_H_STROBE` → all strobes 0 and `o_h_busy`=0 in the same cycle; a new host request is accepted normally after reset release.
